// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and FSM state enums,
// the divide-by-zero quotient constant and the mul/div opcode decode.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SUB   = 4'b0000,
    OP_AND   = 4'b0001,
    OP_XOR   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_ADD   = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_MULHU = 4'b1001,
    OP_DIVU  = 4'b1010,
    OP_REMU  = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_state_e;

  // Quotient bit pattern for a zero divisor; replicated to WIDTH where used.
  localparam logic DIVZERO_QUOT = 1'b1;

  // Mul/div sub-op select: bit 1 = divide, bit 0 = high half / remainder.
  localparam int unsigned MD_OP_W = 2;

  // Opcodes 1000..1011 go through the iterative unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/seq_muldiv_iter.sv
// Radix-2 iterative unsigned multiply / restoring divide.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           load operands and begin WIDTH iterations
//   op[1:0]         00 MUL lo, 01 MUL hi, 10 DIVU, 11 REMU
//   operand1/2      multiplicand/multiplier or dividend/divisor
//   done            high in the cycle whose edge performs the last iteration
//   result          value the last iteration produces (valid while done)
module seq_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // {hi, lo} is the 2*WIDTH accumulator: product for mul, {remainder, quotient} for div.
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mcand;
  logic [MD_OP_W-1:0] op_q;
  logic               div0_q;

  logic [WIDTH-1:0]   hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;

  // One iteration step of either datapath.
  always_comb begin
    sum    = {(WIDTH + 1){1'b0}};
    rem_sh = {(WIDTH + 1){1'b0}};
    hi_nxt = hi;
    lo_nxt = lo;
    if (op_q[1]) begin
      // Restoring divide: shift in next dividend bit, subtract if it fits.
      rem_sh = {hi, lo[WIDTH-1]};
      if (rem_sh >= {1'b0, mcand}) begin
        hi_nxt = WIDTH'(rem_sh - {1'b0, mcand});
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add: conditionally add multiplicand to the high half, then shift right.
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

  assign done = (count == CNT_W'(1));

  // Result taken from the final step so the caller can register it on the same edge.
  always_comb begin
    case (op_q)
      2'b00:   result = lo_nxt;
      2'b01:   result = hi_nxt;
      2'b10:   result = div0_q ? {WIDTH{DIVZERO_QUOT}} : lo_nxt;
      default: result = hi_nxt;  // remainder; equals the dividend when the divisor is 0
    endcase
  end

  // Operand load and iteration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      op_q   <= '0;
      div0_q <= 1'b0;
    end else if (start) begin
      count  <= CNT_W'(WIDTH);
      op_q   <= op;
      hi     <= '0;
      lo     <= op[1] ? operand1 : operand2;
      mcand  <= op[1] ? operand2 : operand1;
      div0_q <= (operand2 == '0);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/add/sub ops plus iterative
// unsigned mul/div, with a registered result held until the consumer accepts.
// Ports:
//   clk_in, reset_in        clock, async active-high reset
//   valid_in / ready_out    request handshake (ready_out is combinational)
//   operand1_in/2_in        operands, captured on acceptance
//   aluOpcode_in            operation select; unknown codes execute as ADD
//   valid_out / ready_in    result handshake
//   result_out              registered result
//   zeroFlag_out            registered, result_out == 0
//   carryFlag_out           registered adder carry-out for ADD/SUB, else 0
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] operand1_in,
  input  logic [WIDTH-1:0] operand2_in,
  input  logic [3:0]       aluOpcode_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             zeroFlag_out,
  output logic             carryFlag_out
);

  alu_state_e state;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;

  // Ready when idle, or when the held result is being retired this cycle.
  assign ready_out = (state == ST_IDLE) || ((state == ST_DONE) && ready_in);
  assign accept    = valid_in && ready_out;
  assign md_start  = accept && is_muldiv(aluOpcode_in);

  // Single-cycle ops; ADD and SUB share one adder (SUB = a + ~b + 1).
  always_comb begin
    sub_op    = (aluOpcode_in == OP_SUB);
    b_eff     = sub_op ? ~operand2_in : operand2_in;
    add_sum   = {1'b0, operand1_in} + {1'b0, b_eff} + (WIDTH + 1)'(sub_op);
    sc_carry  = 1'b0;
    case (aluOpcode_in)
      OP_AND:  sc_result = operand1_in & operand2_in;
      OP_OR:   sc_result = operand1_in | operand2_in;
      OP_XOR:  sc_result = operand1_in ^ operand2_in;
      default: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_carry  = add_sum[WIDTH];
      end
    endcase
  end

  seq_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk_in),
    .rst     (reset_in),
    .start   (md_start),
    .op      (aluOpcode_in[MD_OP_W-1:0]),
    .operand1(operand1_in),
    .operand2(operand2_in),
    .done    (md_done),
    .result  (md_result)
  );

  // Control FSM and output registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state         <= ST_IDLE;
      valid_out     <= 1'b0;
      result_out    <= '0;
      zeroFlag_out  <= 1'b0;
      carryFlag_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_muldiv(aluOpcode_in)) begin
              state     <= ST_BUSY;
              valid_out <= 1'b0;
            end else begin
              state         <= ST_DONE;
              valid_out     <= 1'b1;
              result_out    <= sc_result;
              zeroFlag_out  <= (sc_result == '0);
              carryFlag_out <= sc_carry;
            end
          end else if ((state == ST_DONE) && ready_in) begin
            state     <= ST_IDLE;
            valid_out <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state         <= ST_DONE;
            valid_out     <= 1'b1;
            result_out    <= md_result;
            zeroFlag_out  <= (md_result == '0);
            carryFlag_out <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle datapath ALU. It adds XOR, unsigned multiply (low and high halves) and unsigned divide/remainder, implemented as a radix-2 iterative unit. Single-cycle ops complete in one cycle and mul/div ops take WIDTH+1 cycles. It sits in the execute stage, takes one operation at a time over a valid/ready interface, and holds its registered result until the consumer accepts it.

## Interface
- WIDTH, 64, operand/result width in bits; must be ≥ 2.
- clk_in  input  1  clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  operation request valid.
- ready_out  output  1  block can accept a request this cycle.
- operand1_in  input  WIDTH  first operand / dividend / multiplicand.
- operand2_in  input  WIDTH  second operand / divisor / multiplier.
- aluOpcode_in  input  4  operation select (see Operation).
- valid_out  output  1  result valid; held until accepted.
- ready_in  input  1  consumer accepts the result this cycle.
- result_out  output  WIDTH  registered result.
- zeroFlag_out  output  1  registered; 1 iff result_out == 0.
- carryFlag_out  output  1  registered; carry-out of ADD/SUB (SUB: 1 = no borrow), 0 for all other ops.

## Operation
- Opcodes: 0000 SUB, 0001 AND, 0011 OR, 0111 ADD, 0010 XOR, 1000 MUL (low WIDTH bits of product), 1001 MULHU (high WIDTH bits), 1010 DIVU (quotient), 1011 REMU (remainder). Every other code executes as ADD.
- SUB is operand1 + ~operand2 + 1, from one shared adder. All arithmetic is unsigned and modulo 2^WIDTH.
- A request is accepted on any rising edge where valid_in && ready_out. Operands and opcode are captured at that edge, so inputs may change afterwards.
- FSM states:
  - IDLE, reset state: ready_out = 1.
  - BUSY: mul/div iterating; ready_out = 0.
  - DONE: valid_out = 1; ready_out = ready_in.
- Transitions:
  - IDLE → DONE on accepting a single-cycle op.
  - IDLE → BUSY on accepting a mul/div op. The iteration counter loads WIDTH.
  - BUSY: the counter decrements once per cycle. BUSY → DONE on the edge where the counter reaches 0, and the result is written on that edge.
  - DONE with ready_in = 0: stay in DONE; result and flags are stable.
  - DONE with ready_in = 1 and no new request: go to IDLE.
  - DONE with ready_in = 1 and valid_in = 1: retire the current result and accept the new request on the same edge. Go to DONE or BUSY according to the new opcode.
- Multiply is shift-add over a 2·WIDTH accumulator. Divide is restoring, one quotient bit per cycle.
- Divide by zero: DIVU returns all-ones and REMU returns operand1. There is no exception and latency is the same.
- Unlike the previous ALU, zeroFlag_out reflects result_out for every op, not only the adder output.

## Timing
- Reset values: valid_out = 0, result_out = 0, zeroFlag_out = 0, carryFlag_out = 0, ready_out = 1, state = IDLE, counter = 0.
- Single-cycle op accepted at edge N: valid_out is high from edge N+1. Back-to-back throughput is 1 op/cycle while ready_in = 1.
- Mul/div op accepted at edge N: valid_out rises at edge N+WIDTH+1. For WIDTH = 64 that is 65 cycles.
- reset_in asserted at any time, including mid-BUSY or in DONE under backpressure: all state returns to reset values immediately. The in-flight operation is discarded and never produces valid_out.
- When valid_in is asserted while ready_out = 0, the request is ignored. The requester must hold it until acceptance.

## Structure
- Shared package alu_pkg: the opcode enum (4-bit, the values above), the FSM state enum, and the DIVZERO_QUOT constant (all-ones, sized via WIDTH at use).
- One sub-module, seq_muldiv_iter. It is parametrised by WIDTH and contains the accumulator, the counter and the shift-add / restoring-divide datapath. Ports: start, op (mul/div, hi/lo), operands, done, result.
- The top level holds the FSM, the single-cycle ops and the output registers.

## Test plan
- ADD 5 + 7, ready_in = 1 → result 12, zero = 0, carry = 0, valid_out one cycle after acceptance. Then SUB 3 − 3 on the next cycle → result 0, zero = 1, carry = 1.
- MUL 0xFFFF_FFFF_FFFF_FFFF × 2 → result 0xFFFF_FFFF_FFFF_FFFE after 65 cycles. MULHU with the same operands → result 1. ready_out must stay low during BUSY.
- DIVU 100 / 7 → 14. REMU 100 / 7 → 2. DIVU 9 / 0 → all-ones, zero = 0. REMU 9 / 0 → 9.
- Backpressure: ADD 1 + 1 with ready_in held low for 5 cycles → valid_out = 1 and result = 2 stable throughout; a new valid_in during the stall is not accepted. Releasing ready_in with a new request present → retire and accept on the same edge.
- Assert reset_in 10 cycles into a DIVU → outputs return to reset values immediately and no valid_out follows. A subsequent ADD 2 + 2 → 4 with normal latency.
- Undefined opcode 0101 with operands 3 and 4 → result 7, executed as ADD. Repeat the directed cases at WIDTH = 8 to check parametrisation, including 255 × 255 → low 0x01, high 0xFE.
